// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: word width, reset/NOP/HALT encodings, FSM states.
package fetch_unit_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t DEF_RESET_PC = 16'h0000;
    localparam word_t NOP_WORD     = 16'h0800;
    localparam word_t HALT_WORD    = 16'hF000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DROP   = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

    // Sequential PC step; wraps modulo 2^16.
    function automatic word_t pc_inc(input word_t pc);
        return pc + word_t'(2);
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats load beats hold; otherwise a NOP bubble is inserted.
// One-cycle latency from load_i to outputs; hold_i freezes all contents.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic        hold_i,
    input  logic [15:0] instr_i,
    input  logic [15:0] pc2_i,
    output logic [15:0] instr_o,
    output logic [15:0] pc2_o,
    output logic        valid_o
);

    logic [15:0] instr_q;
    logic [15:0] pc2_q;
    logic        valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc2_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc2_q   <= pc2_i;
            valid_q <= 1'b1;
        end else if (!hold_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end
    end

    assign instr_o = instr_q;
    assign pc2_o   = pc2_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps at most one imem request in flight, feeds IF/ID one word per cycle.
// imem_req/imem_addr are combinational, IF/ID is registered; a response arriving under stall parks in a one-entry buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [15:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_done,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_seen,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc2,
    output logic        id_valid,
    output logic        halted
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] pc_next;
    logic        ifid_load;
    logic        ifid_flush;
    logic [15:0] ifid_instr;

    assign pc_next = pc_inc(pc_q);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        imem_req   = 1'b0;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_instr = imem_data;
        if (state_q == ST_HALTED) begin
            ifid_flush = 1'b1;
        end else if (halt_seen) begin
            state_d    = ST_HALTED;
            ifid_flush = 1'b1;
        end else if (redirect) begin
            // A response still in flight must drain before the new fetch may issue.
            pc_d       = redirect_pc;
            buf_d      = NOP_INSTR;
            ifid_flush = 1'b1;
            state_d    = ((state_q == ST_WAIT || state_q == ST_DROP) && !imem_done) ? ST_DROP : ST_REQ;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    imem_req = 1'b1;
                    state_d  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_done) begin
                        if (stall) begin
                            buf_d   = imem_data;
                            state_d = ST_HOLD;
                        end else begin
                            ifid_load = 1'b1;
                            pc_d      = pc_next;
                            imem_req  = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_load  = 1'b1;
                        ifid_instr = buf_q;
                        pc_d       = pc_next;
                        state_d    = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_done) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // In WAIT the back-to-back request targets the word after the one being delivered.
    assign imem_addr = (state_q == ST_WAIT) ? pc_next : pc_q;
    assign halted    = (state_q == ST_HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            buf_q   <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .flush_i (ifid_flush),
        .load_i  (ifid_load),
        .hold_i  (stall),
        .instr_i (ifid_instr),
        .pc2_i   (pc_next),
        .instr_o (id_instr),
        .pc2_o   (id_pc2),
        .valid_o (id_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: program-order scoreboard plus a variable-latency memory, with literal pins per scenario.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_done;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt_seen;
    logic [15:0] id_instr;
    logic [15:0] id_pc2;
    logic        id_valid;
    logic        halted;

    localparam logic [15:0] NOP = 16'h0800;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_done   (imem_done),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_seen   (halt_seen),
        .id_instr    (id_instr),
        .id_pc2      (id_pc2),
        .id_valid    (id_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int phase  = 0;
    int mem_lat = 1;

    // Program image: word at address a is 16'h4001 + a/2.
    function automatic logic [15:0] memf(input logic [15:0] a);
        return 16'h4001 + {1'b0, a[15:1]};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s phase %0d cycle %0d: got %h expected %h", name, phase, cycle, act, exp);
        end
    endtask

    // Model state: halted flag, next expected request / delivery address, outstanding request.
    logic        m_halted;
    logic [15:0] exp_req, exp_del;
    logic        pend;
    logic [15:0] pend_addr;
    int          pend_cnt;
    logic        p_rst, p_stall, p_flush, p_valid;
    logic [15:0] p_instr, p_pc2;
    int          del_cnt;

    initial begin
        imem_done = 1'b0; imem_data = 16'h0000;
        m_halted = 1'b0; exp_req = 16'h0000; exp_del = 16'h0000;
        pend = 1'b0; pend_addr = 16'h0000; pend_cnt = 0;
        p_rst = 1'b1; p_stall = 1'b0; p_flush = 1'b1; p_valid = 1'b0;
        p_instr = NOP; p_pc2 = 16'h0000; del_cnt = 0;
        forever begin
            @(posedge clk);
            if (rst) cycle = 0; else cycle++;
            #1;
            if (rst || !pend) begin
                imem_done = 1'b0;
                imem_data = 16'hDEAD;
            end else begin
                pend_cnt--;
                imem_done = (pend_cnt == 0);
                imem_data = imem_done ? memf(pend_addr) : 16'hDEAD;
            end
            @(negedge clk);
            if (rst) begin
                chk("rst_req", {15'd0, imem_req}, 16'd0);
                chk("rst_addr", imem_addr, 16'h0000);
                chk("rst_instr", id_instr, NOP);
                chk("rst_pc2", id_pc2, 16'h0000);
                chk("rst_valid", {15'd0, id_valid}, 16'd0);
                chk("rst_halted", {15'd0, halted}, 16'd0);
                m_halted = 1'b0; exp_req = 16'h0000; exp_del = 16'h0000;
                pend = 1'b0; del_cnt = 0; p_rst = 1'b1;
            end else begin
                chk("halted", {15'd0, halted}, {15'd0, m_halted});
                if (p_rst || p_flush) begin
                    chk("flush_valid", {15'd0, id_valid}, 16'd0);
                    chk("flush_instr", id_instr, NOP);
                end else if (p_stall) begin
                    chk("hold_instr", id_instr, p_instr);
                    chk("hold_pc2", id_pc2, p_pc2);
                    chk("hold_valid", {15'd0, id_valid}, {15'd0, p_valid});
                end else if (id_valid) begin
                    chk("del_pc2", id_pc2, exp_del + 16'd2);
                    chk("del_instr", id_instr, memf(exp_del));
                    exp_del = exp_del + 16'd2;
                    del_cnt++;
                end else begin
                    chk("bubble_instr", id_instr, NOP);
                end
                if (imem_done) pend = 1'b0;
                if (imem_req) begin
                    chk("req_overlap", {15'd0, pend}, 16'd0);
                    chk("req_addr", imem_addr, exp_req);
                    exp_req   = exp_req + 16'd2;
                    pend      = 1'b1;
                    pend_addr = imem_addr;
                    pend_cnt  = mem_lat;
                end
                if (m_halted) chk("halted_noreq", {15'd0, imem_req}, 16'd0);
                if (!m_halted) begin
                    if (halt_seen) begin
                        m_halted = 1'b1;
                    end else if (redirect) begin
                        exp_req = redirect_pc;
                        exp_del = redirect_pc;
                    end
                end
                p_flush = m_halted || redirect;
                p_rst   = 1'b0;
                case (phase)
                    1: begin
                        if (cycle == 1) chk("p1_req_addr0", {imem_req, imem_addr[14:0]}, 16'h8000);
                        if (cycle == 2) chk("p1_addr2", imem_addr, 16'h0002);
                        if (cycle == 3) begin
                            chk("p1_first_instr", id_instr, 16'h4001);
                            chk("p1_first_pc2", id_pc2, 16'h0002);
                            chk("p1_first_valid", {15'd0, id_valid}, 16'd1);
                        end
                        if (cycle == 20) chk("p1_deliveries", 16'(del_cnt), 16'd18);
                    end
                    2: begin
                        if (cycle == 4) chk("p2_req_addr2", {imem_req, imem_addr[14:0]}, 16'h8002);
                        if (cycle == 5) begin
                            chk("p2_no_req", {15'd0, imem_req}, 16'd0);
                            chk("p2_first_instr", id_instr, 16'h4001);
                        end
                        if (cycle == 6) chk("p2_gap_valid", {15'd0, id_valid}, 16'd0);
                        if (cycle == 8) begin
                            chk("p2_second_instr", id_instr, 16'h4002);
                            chk("p2_second_pc2", id_pc2, 16'h0004);
                        end
                        if (cycle == 30) chk("p2_deliveries", 16'(del_cnt), 16'd9);
                    end
                    3: begin
                        if (cycle == 12) begin
                            chk("p3_held_instr", id_instr, 16'h4008);
                            chk("p3_held_pc2", id_pc2, 16'h0010);
                            chk("p3_no_req", {15'd0, imem_req}, 16'd0);
                        end
                        if (cycle == 15) begin
                            chk("p3_release_instr", id_instr, 16'h4009);
                            chk("p3_release_pc2", id_pc2, 16'h0012);
                            chk("p3_refetch", {imem_req, imem_addr[14:0]}, 16'h8012);
                        end
                        if (cycle == 16) chk("p3_bubble", {15'd0, id_valid}, 16'd0);
                    end
                    4: begin
                        if (cycle == 7) begin
                            chk("p4_flush_instr", id_instr, 16'h0800);
                            chk("p4_drop_no_req", {15'd0, imem_req}, 16'd0);
                        end
                        if (cycle == 8) chk("p4_redirect_req", {imem_req, imem_addr[14:0]}, 16'h8100);
                        if (cycle == 12) begin
                            chk("p4_target_instr", id_instr, 16'h4081);
                            chk("p4_target_pc2", id_pc2, 16'h0102);
                        end
                    end
                    5: begin
                        if (cycle == 6) chk("p5_addr_fffe", imem_addr, 16'hFFFE);
                        if (cycle == 7) chk("p5_addr_wrap", imem_addr, 16'h0000);
                        if (cycle == 8) begin
                            chk("p5_wrap_instr", id_instr, 16'hC000);
                            chk("p5_wrap_pc2", id_pc2, 16'h0000);
                        end
                    end
                    6: begin
                        if (cycle == 6) chk("p6_not_yet", {15'd0, halted}, 16'd0);
                        if (cycle == 7) chk("p6_halted", {15'd0, halted}, 16'd1);
                        if (cycle == 27) begin
                            chk("p6_still_halted", {15'd0, halted}, 16'd1);
                            chk("p6_no_req", {15'd0, imem_req}, 16'd0);
                            chk("p6_no_valid", {15'd0, id_valid}, 16'd0);
                        end
                    end
                    default: ;
                endcase
            end
            p_stall = stall;
            p_instr = id_instr;
            p_pc2   = id_pc2;
            p_valid = id_valid;
        end
    end

    task automatic goto(input int k);
        for (int i = 0; i < 500 && cycle < k; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int lat, input int ph);
        @(posedge clk); #1;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; halt_seen = 1'b0;
        redirect_pc = 16'h0000; phase = 0; mem_lat = lat;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0; phase = ph;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; halt_seen = 1'b0;
        do_reset(1, 1); goto(21);
        do_reset(3, 2); goto(31);
        do_reset(1, 3); goto(10); stall = 1'b1; goto(14); stall = 1'b0; goto(20);
        do_reset(3, 4); goto(6); redirect = 1'b1; redirect_pc = 16'h0100;
        goto(7); redirect = 1'b0; goto(16);
        do_reset(1, 5); goto(5); redirect = 1'b1; redirect_pc = 16'hFFFE;
        goto(6); redirect = 1'b0; goto(12);
        do_reset(1, 6); goto(6); halt_seen = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
        goto(7); halt_seen = 1'b0; redirect = 1'b0; goto(28);
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
